pio_cmd_sequencer: RTL and testbench

- Consumes the 18-bit command word driven by the HPS-written output PIO and turns it into a one-command-at-a-time transaction to a fabric coprocessor.
- Handshake with software is four-phase: a request bit in the word, and a status nibble returned through an input PIO.
- Latches opcode and operand, issues them with valid/ready, waits for completion with a timeout, and holds a completion status until software drops the request.

---
 rtl/pio_cmd_sequencer_if.sv | 23 ++
 rtl/pio_cmd_sequencer.sv | 132 +++++++++++++
 tb/tb_pio_cmd_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pio_cmd_sequencer_if.sv
// Coprocessor command channel: one command (opcode + operand) handed over
// with valid/ready, completion reported by a single-cycle done pulse.
`timescale 1ns/1ps
interface pio_cmd_sequencer_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [13:0] op_data;
    logic        op_ready;
    logic        op_done;
    logic        op_error;

    // Sequencer side issues commands and watches for completion
    modport master (
        output op_valid, op_code, op_data,
        input  op_ready, op_done, op_error
    );

    // Coprocessor side accepts commands and reports completion
    modport slave (
        input  op_valid, op_code, op_data,
        output op_ready, op_done, op_error
    );
endinterface

// File: rtl/pio_cmd_sequencer.sv
// Turns the HPS PIO command word into a single outstanding coprocessor
// command. Software raises req, polls status for done, then drops req;
// status is held until req drops so a slow poller never misses it.
`timescale 1ns/1ps
module pio_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int NUM_OPCODES    = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [17:0]            cmd_word,
    output logic [3:0]             status,
    pio_cmd_sequencer_if.master    cop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_COMPLETE
    } state_t;

    // Terminal EXEC count and legal-opcode bound, sized to the compared fields
    localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  OP_LIMIT = 4'(NUM_OPCODES);

    localparam logic [3:0] ST_BUSY    = 4'b0010;
    localparam logic [3:0] ST_TIMEOUT = 4'b1101;  // timeout + error + done
    localparam logic [3:0] ST_REJECT  = 4'b0101;  // error + done

    logic        req;
    logic [2:0]  req_op;
    logic [13:0] req_data;
    logic        op_legal;

    state_t      state_q, state_d;
    logic        op_valid_q, op_valid_d;
    logic [2:0]  op_code_q, op_code_d;
    logic [13:0] op_data_q, op_data_d;
    logic [3:0]  status_q, status_d;
    logic [15:0] cnt_q, cnt_d;

    assign req      = cmd_word[17];
    assign req_op   = cmd_word[16:14];
    assign req_data = cmd_word[13:0];
    assign op_legal = ({1'b0, req_op} < OP_LIMIT);

    // State register and registered outputs; reset drops op_valid at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_valid_q <= 1'b0;
            op_code_q  <= 3'd0;
            op_data_q  <= 14'd0;
            status_q   <= 4'd0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            op_valid_q <= op_valid_d;
            op_code_q  <= op_code_d;
            op_data_q  <= op_data_d;
            status_q   <= status_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and output logic; every register holds unless a state acts
    always_comb begin
        state_d    = state_q;
        op_valid_d = op_valid_q;
        op_code_d  = op_code_q;
        op_data_d  = op_data_q;
        status_d   = status_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Command fields are frozen here until we return to IDLE
                if (req) begin
                    op_code_d = req_op;
                    op_data_d = req_data;
                    if (op_legal) begin
                        state_d    = S_ISSUE;
                        op_valid_d = 1'b1;
                        status_d   = ST_BUSY;
                    end else begin
                        // Reserved opcode never reaches the coprocessor
                        state_d  = S_COMPLETE;
                        status_d = ST_REJECT;
                    end
                end
            end

            S_ISSUE: begin
                // No timeout while waiting for acceptance: stalls are legal
                if (op_valid_q && cop.op_ready) begin
                    state_d    = S_EXEC;
                    op_valid_d = 1'b0;
                    cnt_d      = 16'd0;
                end
            end

            S_EXEC: begin
                cnt_d = cnt_q + 16'd1;
                // Completion takes priority over a coincident terminal count
                if (cop.op_done) begin
                    state_d  = S_COMPLETE;
                    status_d = {1'b0, cop.op_error, 1'b0, 1'b1};
                end else if (cnt_q == TERM_CNT) begin
                    state_d  = S_COMPLETE;
                    status_d = ST_TIMEOUT;
                end
            end

            S_COMPLETE: begin
                // Only a dropped req releases us, so a held req cannot retrigger
                if (!req) begin
                    state_d  = S_IDLE;
                    status_d = 4'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign status       = status_q;
    assign cop.op_valid = op_valid_q;
    assign cop.op_code  = op_code_q;
    assign cop.op_data  = op_data_q;

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer with a short timeout so the timeout
// and backpressure cases stay small. Inputs change and outputs are sampled
// on the falling edge.
`timescale 1ns/1ps
module tb_pio_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic [17:0] cmd_word;
    logic [3:0]  status;

    int n_chk;
    int n_bad;

    pio_cmd_sequencer_if bus ();

    pio_cmd_sequencer #(
        .TIMEOUT_CYCLES (8),
        .NUM_OPCODES    (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_word (cmd_word),
        .status   (status),
        .cop      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    // {op_valid, op_code, op_data, status} packed for one-shot checks
    function automatic logic [31:0] pk(input logic v, input logic [2:0] c,
                                       input logic [13:0] d, input logic [3:0] s);
        return {10'd0, v, c, d, s};
    endfunction

    logic [31:0] outs;
    assign outs = pk(bus.op_valid, bus.op_code, bus.op_data, status);

    initial begin
        n_chk        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        cmd_word     = 18'd0;
        bus.op_ready = 1'b0;
        bus.op_done  = 1'b0;
        bus.op_error = 1'b0;

        #3;
        chk("reset_outs", outs, pk(1'b0, 3'd0, 14'd0, 4'h0));
        nedge(1);
        reset = 1'b0;

        // Normal command: op=1 data=0x123
        nedge(1);
        cmd_word = 18'h2_4123; bus.op_ready = 1'b1;
        nedge(1);
        chk("norm_issue", outs, pk(1'b1, 3'd1, 14'h0123, 4'h2));
        nedge(1);
        chk("norm_accepted", outs, pk(1'b0, 3'd1, 14'h0123, 4'h2));
        nedge(3);
        chk("norm_busy", outs, pk(1'b0, 3'd1, 14'h0123, 4'h2));
        nedge(1);
        bus.op_done = 1'b1;
        nedge(1);
        bus.op_done = 1'b0;
        chk("norm_done", status, 4'h1);
        nedge(1);
        chk("norm_done_held", status, 4'h1);
        cmd_word = 18'd0;
        nedge(1);
        chk("norm_cleared", status, 4'h0);

        // Completion pulse while idle is ignored
        bus.op_done = 1'b1;
        nedge(1);
        bus.op_done = 1'b0;
        chk("idle_done_ignored", outs, pk(1'b0, 3'd1, 14'h0123, 4'h0));

        // Backpressure: 20 stalled cycles, fields frozen, no timeout
        bus.op_ready = 1'b0;
        cmd_word = 18'h2_8055;
        for (int i = 0; i < 20; i++) begin
            nedge(1);
            chk("bp_hold", outs, pk(1'b1, 3'd2, 14'h0055, 4'h2));
            if (i == 5)  cmd_word = 18'h3_FFFF;
            if (i == 10) bus.op_done = 1'b1;
            if (i == 11) bus.op_done = 1'b0;
        end
        bus.op_ready = 1'b1;
        nedge(1);
        chk("bp_accepted", outs, pk(1'b0, 3'd2, 14'h0055, 4'h2));
        bus.op_done = 1'b1;
        nedge(1);
        bus.op_done = 1'b0;
        chk("bp_done", outs, pk(1'b0, 3'd2, 14'h0055, 4'h1));
        cmd_word = 18'd0;
        nedge(1);
        chk("bp_cleared", status, 4'h0);

        // Reserved opcode 7: rejected without ever asserting op_valid
        cmd_word = 18'h3_C000;
        nedge(1);
        chk("rsv_status", {31'd0, bus.op_valid} << 4 | {28'd0, status}, 32'h05);
        nedge(1);
        chk("rsv_held", {31'd0, bus.op_valid} << 4 | {28'd0, status}, 32'h05);
        cmd_word = 18'd0;
        nedge(1);
        chk("rsv_cleared", status, 4'h0);

        // Timeout: EXEC entered 2 edges after capture, abort 8 cycles later
        cmd_word = 18'h2_0007;
        nedge(9);
        chk("to_busy_last", status, 4'h2);
        nedge(1);
        chk("to_fired", status, 4'hD);
        nedge(1);
        chk("to_held", status, 4'hD);
        cmd_word = 18'd0;
        nedge(1);
        chk("to_cleared", status, 4'h0);

        // op_done on the terminal-count cycle wins over timeout
        cmd_word = 18'h2_0007;
        nedge(9);
        chk("term_busy", status, 4'h2);
        bus.op_done = 1'b1;
        nedge(1);
        bus.op_done = 1'b0;
        chk("term_done_wins", status, 4'h1);
        cmd_word = 18'd0;
        nedge(1);
        chk("term_cleared", status, 4'h0);

        // Coprocessor error with req dropped early during EXEC
        cmd_word = 18'h2_4ABC;
        nedge(2);
        cmd_word = 18'd0;
        nedge(1);
        chk("err_still_busy", status, 4'h2);
        bus.op_done = 1'b1; bus.op_error = 1'b1;
        nedge(1);
        bus.op_done = 1'b0; bus.op_error = 1'b0;
        chk("err_status", status, 4'h5);
        nedge(1);
        chk("err_cleared", status, 4'h0);
        nedge(1);
        chk("err_idle_stays", outs, pk(1'b0, 3'd1, 14'h0ABC, 4'h0));

        // Async reset while op_valid is high (stalled in ISSUE)
        bus.op_ready = 1'b0;
        cmd_word = 18'h2_8001;
        nedge(1);
        chk("rst_issue_pre", outs, pk(1'b1, 3'd2, 14'h0001, 4'h2));
        #2 reset = 1'b1;
        #1 chk("rst_issue_async", outs, pk(1'b0, 3'd0, 14'd0, 4'h0));
        nedge(1);
        reset = 1'b0; bus.op_ready = 1'b1;
        nedge(1);
        chk("rst_recapture", outs, pk(1'b1, 3'd2, 14'h0001, 4'h2));

        // Async reset mid-EXEC
        nedge(1);
        chk("rst_exec_pre", outs, pk(1'b0, 3'd2, 14'h0001, 4'h2));
        #2 reset = 1'b1;
        #1 chk("rst_exec_async", outs, pk(1'b0, 3'd0, 14'd0, 4'h0));
        nedge(1);
        reset = 1'b0;
        nedge(1);
        chk("rst_exec_recapture", outs, pk(1'b1, 3'd2, 14'h0001, 4'h2));
        nedge(1);
        bus.op_done = 1'b1;
        nedge(1);
        bus.op_done = 1'b0;
        chk("rst_final_done", status, 4'h1);
        cmd_word = 18'd0;
        nedge(1);
        chk("rst_final_cleared", status, 4'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
